key_event_poller: RTL

Avalon-MM initiator that services the 4-bit push-button PIO in the DE10-Lite Qsys system so software and downstream logic do not have to. On a programmable poll interval it reads the PIO edge-capture register, clears it by writing back, and presents every nonzero capture as a one-beat event on a valid/ready output. It sits beside the Nios II as a second master on the PIO slave port and feeds game-input logic directly.

---
 rtl/key_event_pkg.sv | 18 +
 rtl/key_event_slot.sv | 49 ++++
 rtl/key_event_poller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared definitions for the key event poller.
//   state_e   - poller FSM states
//   *_OFS     - key PIO register byte offsets relative to its base address
package key_event_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_CLR
  } state_e;

  localparam int unsigned DATA_OFS = 0;
  localparam int unsigned MASK_OFS = 8;
  localparam int unsigned EDGE_OFS = 12;

endpackage

// File: rtl/key_event_slot.sv
// key_event_slot: one-deep event buffer with merge-on-full.
//   clk, rst     - clock, asynchronous active-high reset
//   load_i       - a nonzero capture is presented this cycle
//   data_i       - captured key edges
//   ready_i      - consumer accepts the pending event
//   valid_o      - event pending
//   data_o       - pending key edges, stable until accepted
//   overflow_o   - sticky: a capture was merged into an unconsumed event
module key_event_slot #(
  parameter int unsigned KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [KEY_W-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [KEY_W-1:0] data_o,
  output logic             overflow_o
);

  logic             valid_q;
  logic [KEY_W-1:0] data_q;
  logic             ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (load_i) begin
      // A slot being drained this same cycle counts as empty.
      if (!valid_q || ready_i) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else begin
        data_q <= data_q | data_i;
        ovf_q  <= 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/key_event_poller.sv
// key_event_poller: Avalon-MM initiator that polls the key PIO edge-capture
// register, clears it by write-back and emits nonzero captures as events.
// Optional feature macro: KEY_EVENT_POLLER_IRQ_EN (irq port, MASK init write,
// irq-triggered early poll).
//   clk, reset                   - clock, asynchronous active-high reset
//   avm_address/read/write/      - Avalon-MM initiator request (registered)
//   avm_writedata
//   avm_readdata/waitrequest/    - Avalon-MM slave response
//   avm_readdatavalid
//   evt_valid/evt_data/evt_ready - one-beat event output
//   overflow                     - sticky event-merge flag
//   irq                          - PIO interrupt (macro builds only)
module key_event_poller
  import key_event_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned KEY_W       = 4,
  parameter int unsigned POLL_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic              evt_valid,
  output logic [KEY_W-1:0]  evt_data,
  input  logic              evt_ready,
  output logic              overflow
`ifdef KEY_EVENT_POLLER_IRQ_EN
  ,
  input  logic              irq
`endif
);

  localparam int unsigned CW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_LOAD  = CW'(POLL_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR + DATA_OFS);
  localparam logic [ADDR_W-1:0] ADDR_EDGE = ADDR_W'(BASE_ADDR + EDGE_OFS);
`ifdef KEY_EVENT_POLLER_IRQ_EN
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BASE_ADDR + MASK_OFS);
  localparam logic [KEY_W-1:0]  KEY_ALL   = '1;
`endif

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [KEY_W-1:0]  cap_d;
  logic              load_d;
  logic              poll_now_d;
  logic              unused_rdata;

  assign cap_d        = avm_readdata[KEY_W-1:0];
  assign unused_rdata = ^avm_readdata[31:KEY_W];
  // The slot is loaded straight from the response beat so evt_valid rises on
  // the same edge that enters CLR.
  assign load_d       = (state_q == S_RWAIT) && avm_readdatavalid && (cap_d != '0);

`ifdef KEY_EVENT_POLLER_IRQ_EN
  assign poll_now_d = (cnt_q == '0) || irq;
`else
  assign poll_now_d = (cnt_q == '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= CNT_LOAD;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= ADDR_BASE;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
`ifdef KEY_EVENT_POLLER_IRQ_EN
          if (!write_q) begin
            write_q <= 1'b1;
            addr_q  <= ADDR_MASK;
            wdata_q <= 32'(KEY_ALL);
          end else if (!avm_waitrequest) begin
            write_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= CNT_LOAD;
          end
`else
          state_q <= S_IDLE;
          cnt_q   <= CNT_LOAD;
`endif
        end
        S_IDLE: begin
          if (poll_now_d) begin
            state_q <= S_RD;
            read_q  <= 1'b1;
            addr_q  <= ADDR_EDGE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RD: begin
          if (!avm_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (avm_readdatavalid) begin
            if (cap_d != '0) begin
              state_q <= S_CLR;
              write_q <= 1'b1;
              wdata_q <= 32'(cap_d);
            end else begin
              state_q <= S_IDLE;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        S_CLR: begin
          if (!avm_waitrequest) begin
            write_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= CNT_LOAD;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;

  key_event_slot #(
    .KEY_W (KEY_W)
  ) u_slot (
    .clk        (clk),
    .rst        (reset),
    .load_i     (load_d),
    .data_i     (cap_d),
    .ready_i    (evt_ready),
    .valid_o    (evt_valid),
    .data_o     (evt_data),
    .overflow_o (overflow)
  );

endmodule
